debounce_scan_ctrl: RTL and testbench
=====================================

# debounce_scan_ctrl

Multi-button debounce controller and event arbiter. It shares one tick prescaler across N_BTN raw push-button inputs and debounces each one into a registered clean level. It turns each qualified level change into a press/release event, and the events from all channels are arbitrated round-robin onto one valid/ready event port for the downstream game/menu logic.

## Interface
Parameters:
- N_BTN, 4, number of button channels (2..16)
- TICK_CYCLES, 12000, clk cycles per sample tick (1 ms at 12 MHz); ≥2
- STABLE_TICKS, 20, consecutive differing ticks required to accept a change; 2..31
- ID_W, 2, width of evt_id; must satisfy 2^ID_W ≥ N_BTN

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  N_BTN  raw bouncing button levels, asynchronous to clk
- btn_clean  out  N_BTN  debounced levels, registered
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_id  out  ID_W  channel index of the presented event
- evt_press  out  1  1 = press (0→1), 0 = release (1→0)
- overflow  out  1  sticky: an un-presented event was overwritten
- ovf_clr  in  1  single-cycle clear of overflow

## Operation
- Reset (async assert, sync deassert externally): btn_clean=0, evt_valid=0, evt_id=0, evt_press=0, overflow=0. Sync flops, tick counter, per-channel counters, pending flags and the RR pointer are all 0.
- Synchronizer: 2-flop per channel. sync[i] is btn_raw[i] delayed 2 cycles.
- Prescaler: tcnt runs 0..TICK_CYCLES-1 and wraps. tick=1 for the single cycle with tcnt==TICK_CYCLES-1.
- Per channel i, on a tick cycle:
  - sync[i]==btn_clean[i]: scnt[i] ← 0.
  - differs and scnt[i] < STABLE_TICKS-1: scnt[i] ← scnt[i]+1.
  - differs and scnt[i]==STABLE_TICKS-1: btn_clean[i] ← sync[i], scnt[i] ← 0, pend[i] ← 1, pol[i] ← sync[i].
- Non-tick cycles: scnt unchanged. A mismatch appearing between ticks is not seen until the next tick.
- Output slot is free when evt_valid==0 or (evt_valid && evt_ready).
- When the slot is free and any pend is set:
  - Search starts at ptr: ptr, ptr+1, … mod N_BTN.
  - The first pending channel g is loaded: evt_id←g, evt_press←pol[g], evt_valid←1, pend[g]←0, ptr←(g+1) mod N_BTN.
- When the slot is free and nothing is pending, evt_valid←0.
- While evt_valid=1 and evt_ready=0, evt_id and evt_press hold stable.
- Simultaneous events:
  - Channel qualifies in the same cycle its pending is granted: the granted event goes out, and the new edge sets pend/pol (set wins).
  - Channel qualifies while pend already set and not granted this cycle: pol is overwritten with the new polarity and overflow←1.
  - Overflow set and ovf_clr in the same cycle: set wins.

## Timing
- Raw-to-clean latency: 2 cycles sync, plus the wait to the next tick, plus STABLE_TICKS-1 further ticks. btn_clean updates at the clock edge ending the STABLE_TICKS-th consecutive differing tick.
- Range: 2 + (STABLE_TICKS-1)·TICK_CYCLES + 1 to 2 + STABLE_TICKS·TICK_CYCLES cycles.
- Event latency: evt_valid rises 1 cycle after pend is set if the slot is free.
- Throughput: back-to-back events on consecutive cycles while evt_ready=1.
- Any glitch shorter than one tick period that is sampled at a tick resets that channel's qualification.

## Test plan
Bench parameters: N_BTN=4, TICK_CYCLES=4, STABLE_TICKS=3, ID_W=2.
- Reset: assert rst_n=0 with btn_raw=4'hF → all outputs 0 immediately. After release, btn_clean=4'hF after ≤15 cycles, with events in order id 0,1,2,3, all press=1.
- Held press with stalled consumer: btn_raw[1]=1 held, evt_ready=0 → btn_clean[1]=1 within 10–14 cycles. One cycle later evt_valid=1, evt_id=1, evt_press=1, held stable for 20 cycles. Then evt_ready=1 for one cycle → evt_valid=0 the next cycle.
- Bounce: btn_raw[0] toggled every 4 cycles for 40 cycles, then returned to 0 → btn_clean[0] stays 0 and evt_valid never asserts.
- Round-robin: ch0 granted last (ptr=1); ch0 and ch2 release on the same tick, evt_ready=1 → events id=2 then id=0 on consecutive cycles, both evt_press=0.
- Overflow: evt_ready=0; ch3 goes press, release, press, each held ≥15 cycles → output holds (3,press), overflow=1. After evt_ready=1 → second event is (3,press). ovf_clr pulse → overflow=0.
- Reset mid-operation: rst_n low while evt_valid=1 and scnt>0 → all outputs 0 asynchronously. After release with btn_raw[2] high → btn_clean[2] rises only after a full re-qualification (≥10 cycles).

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// Multi-button debounce controller with round-robin event arbitration.
// One shared tick prescaler samples N_BTN synchronized button inputs. Each channel
// must differ from its clean level on STABLE_TICKS consecutive ticks before the
// change is accepted. Every accepted change becomes a press/release event, and
// events from all channels share one valid/ready port via a round-robin arbiter.
module debounce_scan_ctrl #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_CYCLES  = 12000,
    parameter int unsigned STABLE_TICKS = 20,
    parameter int unsigned ID_W         = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_press,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int unsigned TcntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned ScntW = 5;

    localparam logic [TcntW-1:0] TcntMax = TcntW'(TICK_CYCLES - 1);
    localparam logic [ScntW-1:0] ScntMax = ScntW'(STABLE_TICKS - 1);
    localparam logic [ID_W-1:0]  LastId  = ID_W'(N_BTN - 1);

    // Two-flop synchronizer
    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;

    // Shared sample prescaler
    logic [TcntW-1:0] tcnt_q;
    logic [TcntW-1:0] tcnt_d;
    logic             tick;

    // Per-channel qualification
    logic [N_BTN-1:0][ScntW-1:0] scnt_q;
    logic [N_BTN-1:0][ScntW-1:0] scnt_d;
    logic [N_BTN-1:0]            clean_q;
    logic [N_BTN-1:0]            clean_d;
    logic [N_BTN-1:0]            qual;

    // Pending events and their polarity (1 = press)
    logic [N_BTN-1:0] pend_q;
    logic [N_BTN-1:0] pend_d;
    logic [N_BTN-1:0] pol_q;
    logic [N_BTN-1:0] pol_d;

    // Round-robin arbiter
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] grant_next;
    logic            grant_any;
    logic            slot_free;
    logic            do_grant;

    // Output event slot
    logic            valid_q;
    logic            valid_d;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] id_d;
    logic            press_q;
    logic            press_d;
    logic            ovf_q;
    logic            ovf_d;

    // Bring raw asynchronous levels into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    // Prescaler wraps at TICK_CYCLES-1; tick is the single wrap cycle
    always_comb begin
        tick   = (tcnt_q == TcntMax);
        tcnt_d = tick ? '0 : tcnt_q + TcntW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    // Count consecutive differing ticks; accept the change on the last one
    always_comb begin
        scnt_d  = scnt_q;
        clean_d = clean_q;
        qual    = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (tick) begin
                if (sync_q[i] == clean_q[i]) begin
                    scnt_d[i] = '0;
                end else if (scnt_q[i] == ScntMax) begin
                    clean_d[i] = sync_q[i];
                    scnt_d[i]  = '0;
                    qual[i]    = 1'b1;
                end else begin
                    scnt_d[i] = scnt_q[i] + ScntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q  <= '0;
            clean_q <= '0;
        end else begin
            scnt_q  <= scnt_d;
            clean_q <= clean_d;
        end
    end

    // Find the first pending channel at or after the round-robin pointer
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            scan_idx = ID_W'((32'(ptr_q) + k) % N_BTN);
            if (!grant_any && pend_q[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_next = (grant_idx == LastId) ? '0 : grant_idx + ID_W'(1);
    end

    // Slot handoff, pending bookkeeping and sticky overflow
    always_comb begin
        slot_free = !valid_q || evt_ready;
        do_grant  = slot_free && grant_any;

        pend_d  = pend_q;
        pol_d   = pol_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        id_d    = id_q;
        press_d = press_q;
        ptr_d   = ptr_q;

        if (slot_free) begin
            valid_d = grant_any;
        end
        if (do_grant) begin
            id_d              = grant_idx;
            press_d           = pol_q[grant_idx];
            pend_d[grant_idx] = 1'b0;
            ptr_d             = grant_next;
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // A new edge always lands in pend/pol; if an older event was still
        // waiting (and not granted this cycle) it is lost, so flag it.
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (qual[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                pol_d[i]  = sync_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            pol_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            press_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            pol_q   <= pol_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            press_q <= press_d;
            ovf_q   <= ovf_d;
        end
    end

    assign btn_clean = clean_q;
    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign evt_press = press_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the debounce/arbiter rules.
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam int IW = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic [N-1:0]  btn_raw   = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic [N-1:0]  btn_clean;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_press;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    debounce_scan_ctrl #(
        .N_BTN       (N),
        .TICK_CYCLES (TC),
        .STABLE_TICKS(ST),
        .ID_W        (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_press(evt_press),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    // Behavioural model: clean level, run length of differing ticks, pending
    // events, last granted channel, and the presented event.
    logic [N-1:0] m_clean;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_pol;
    int           m_run[N];
    logic         m_valid;
    int           m_id;
    logic         m_press;
    logic         m_ovf;
    int           m_last;
    int           n_edges;
    logic [N-1:0] raw_hist[$];

    task automatic model_reset();
        m_clean = '0;
        m_pend  = '0;
        m_pol   = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_valid = 1'b0;
        m_id    = 0;
        m_press = 1'b0;
        m_ovf   = 1'b0;
        m_last  = N - 1;
        n_edges = 0;
        raw_hist.delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] sync_now;
        logic [N-1:0] newev;
        bit           tick_now;
        bit           found;
        int           g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Value seen by the debouncer is the raw level sampled two edges ago
        sync_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : '0;
        raw_hist.push_back(btn_raw);
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        tick_now = ((n_edges % TC) == TC - 1);
        n_edges++;

        newev = '0;
        if (tick_now) begin
            for (int i = 0; i < N; i++) begin
                if (sync_now[i] != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == ST) begin
                        m_clean[i] = sync_now[i];
                        m_run[i]   = 0;
                        newev[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end

        if (!m_valid || evt_ready) begin
            found = 0;
            g     = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m_pend[(m_last + k) % N]) begin
                    found = 1;
                    g     = (m_last + k) % N;
                end
            end
            m_valid = found;
            if (found) begin
                m_id      = g;
                m_press   = m_pol[g];
                m_pend[g] = 1'b0;
                m_last    = g;
            end
        end

        if (ovf_clr) m_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (newev[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1;
                m_pol[i]  = sync_now[i];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model", 32'({btn_clean, evt_valid, evt_id, evt_press, overflow}),
            32'({m_clean, m_valid, IW'(m_id), m_press, m_ovf}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int   n;
        bit   seen;
        bit   stable_bad;
        int   ev_id[$];
        int   ev_pr[$];
        int   ev_cy[$];
        int   len;

        model_reset();

        // Reset with all buttons held
        btn_raw = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({btn_clean, evt_valid, evt_id, evt_press, overflow}), 32'(0));
        step();
        step();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        n = 0;
        while (btn_clean !== 4'hF && n < 20) begin
            step();
            n++;
        end
        chk("reset_clean_latency", 32'(n <= 15 && btn_clean === 4'hF), 32'(1));
        ev_id.delete(); ev_pr.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            if (evt_valid) begin
                ev_id.push_back(int'(evt_id));
                ev_pr.push_back(int'(evt_press));
            end
        end
        chk("reset_evt_count", 32'(ev_id.size()), 32'(4));
        if (ev_id.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("reset_evt_id", 32'(ev_id[k]), 32'(k));
                chk("reset_evt_press", 32'(ev_pr[k]), 32'(1));
            end
        end

        // Release all, drain, then held press with stalled consumer
        btn_raw = '0;
        repeat (30) step();
        evt_ready = 1'b0;
        btn_raw   = 4'b0010;
        n = 0;
        while (!btn_clean[1] && n < 20) begin
            step();
            n++;
        end
        chk("press_latency", 32'(n >= 10 && n <= 14 && btn_clean[1]), 32'(1));
        step();
        chk("press_evt", 32'({evt_valid, evt_id, evt_press}), 32'(4'b1011));
        stable_bad = 0;
        repeat (20) begin
            step();
            if ({evt_valid, evt_id, evt_press} !== 4'b1011) stable_bad = 1;
        end
        chk("press_hold_stable", 32'(stable_bad), 32'(0));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("press_accept", 32'(evt_valid), 32'(0));

        // Bounce on channel 0: toggling every tick period never qualifies
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            btn_raw[0] = ~btn_raw[0];
            repeat (4) begin
                step();
                if (evt_valid) seen = 1;
            end
        end
        btn_raw[0] = 1'b0;
        repeat (20) begin
            step();
            if (evt_valid) seen = 1;
        end
        chk("bounce_clean", 32'(btn_clean[0]), 32'(0));
        chk("bounce_no_evt", 32'(seen), 32'(0));

        // Round-robin: ch2 then ch0 pressed (ptr ends at 1), both released together
        evt_ready = 1'b1;
        btn_raw   = 4'b0110;
        repeat (20) step();
        btn_raw = 4'b0111;
        repeat (20) step();
        btn_raw = 4'b0010;
        ev_id.delete(); ev_pr.delete(); ev_cy.delete();
        for (int k = 0; k < 25; k++) begin
            step();
            if (evt_valid) begin
                ev_id.push_back(int'(evt_id));
                ev_pr.push_back(int'(evt_press));
                ev_cy.push_back(k);
            end
        end
        chk("rr_count", 32'(ev_id.size()), 32'(2));
        if (ev_id.size() == 2) begin
            chk("rr_first_id", 32'(ev_id[0]), 32'(2));
            chk("rr_second_id", 32'(ev_id[1]), 32'(0));
            chk("rr_press", 32'({ev_pr[0][0], ev_pr[1][0]}), 32'(0));
            chk("rr_back_to_back", 32'(ev_cy[1] - ev_cy[0]), 32'(1));
        end

        // Overflow: press, release, press on ch3 while the consumer stalls
        evt_ready = 1'b0;
        btn_raw   = 4'b1010;
        repeat (16) step();
        btn_raw = 4'b0010;
        repeat (16) step();
        btn_raw = 4'b1010;
        repeat (16) step();
        chk("ovf_hold", 32'({evt_valid, evt_id, evt_press, overflow}), 32'(5'b1_11_1_1));
        evt_ready = 1'b1;
        step();
        chk("ovf_second_evt", 32'({evt_valid, evt_id, evt_press}), 32'(4'b1111));
        step();
        evt_ready = 1'b0;
        chk("ovf_drained", 32'(evt_valid), 32'(0));
        chk("ovf_sticky", 32'(overflow), 32'(1));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'(0));

        // Reset mid-operation with an event waiting and ch0 qualifying
        btn_raw = 4'b0110;
        n = 0;
        while (!evt_valid && n < 20) begin
            step();
            n++;
        end
        chk("midrst_evt_pending", 32'(evt_valid), 32'(1));
        btn_raw = 4'b0111;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 32'({btn_clean, evt_valid, evt_id, evt_press, overflow}), 32'(0));
        step();
        step();
        btn_raw = 4'b0100;
        rst_n   = 1'b1;
        n = 0;
        while (!btn_clean[2] && n < 25) begin
            step();
            n++;
        end
        chk("midrst_requalify", 32'(n >= 10 && btn_clean[2]), 32'(1));

        // Random traffic against the model
        for (int s = 0; s < 150; s++) begin
            btn_raw = N'($urandom);
            len     = int'($urandom_range(1, 20));
            repeat (len) begin
                evt_ready = (($urandom % 4) != 0);
                ovf_clr   = (($urandom % 16) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
